// File: rtl/msk_pkg.sv
// Shared helpers for the masked-AND scheduler: port-width functions and the
// mapping from an unordered share pair to its randomness bit.
package msk_pkg;

    // Randomness bits consumed per HPC3 multiplication.
    function automatic int hpc3_rnd(input int d);
        return d * (d - 1);
    endfunction

    // Requester-id width, never below one bit.
    function automatic int idw(input int n);
        return ($clog2(n) > 1) ? $clog2(n) : 1;
    endfunction

    // Dense index of unordered share pair {i,j} with i < j, range 0 .. d*(d-1)/2-1.
    function automatic int pair_idx(input int d, input int i, input int j);
        return i * d - (i * (i + 1)) / 2 + (j - i - 1);
    endfunction

endpackage

// File: rtl/mskand_hpc3_sched_rr_arb.sv
// Round-robin picker: first asserted request at or after the pointer wins.
// Combinational only; the caller owns the pointer register.
module rr_arb import msk_pkg::*; #(
    parameter  int N  = 4,
    localparam int IW = idw(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_winner,
    output logic          o_any
);

    always_comb begin
        int idx;
        // NOTE: every output gets a default before the loop so no path leaves one unassigned (no latch).
        o_grant  = '0;
        o_winner = '0;
        o_any    = 1'b0;
        idx      = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(i_ptr) + k) % N;
            if (!o_any && i_req[idx]) begin
                o_any        = 1'b1;
                o_grant[idx] = 1'b1;
                o_winner     = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/mskand_hpc3_sched.sv
// Shares one HPC3 masked-AND gadget between N requesters: round-robin issue with
// fresh randomness, 1-cycle gadget, 2-entry result FIFO tagged with requester id.
module mskand_hpc3_sched import msk_pkg::*; #(
    parameter  int D  = 2,
    parameter  int N  = 4,
    localparam int RW = hpc3_rnd(D),
    localparam int IW = idw(N),
    localparam int NP = D * (D - 1) / 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req_valid,
    output logic [N-1:0]    req_ready,
    input  logic [N*D-1:0]  req_ina,
    input  logic [N*D-1:0]  req_inb,
    input  logic            rnd_valid,
    output logic            rnd_ready,
    input  logic [RW-1:0]   rnd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [D-1:0]    out_data,
    output logic [IW-1:0]   out_id,
    output logic            busy
);

    logic              r_en;
    logic [IW-1:0]     r_ptr;
    logic              r_inflight;
    logic [IW-1:0]     r_fly_id;
    logic [D-1:0]      r_mem_data [2];
    logic [IW-1:0]     r_mem_id   [2];
    logic              r_wr;
    logic              r_rd;
    logic [1:0]        r_occ;

    logic [N-1:0]      w_grant;
    logic [IW-1:0]     w_winner;
    logic              w_any;
    logic              w_pop;
    logic              w_push;
    logic              w_issue;
    logic [1:0]        w_credits;
    logic [D-1:0]      w_a;
    logic [D-1:0]      w_b;
    logic [D-1:0]      w_gad;
    logic [D-1:0][D-1:0] w_term;

    rr_arb #(.N(N)) u_arb (
        .i_req    (req_valid),
        .i_ptr    (r_ptr),
        .o_grant  (w_grant),
        .o_winner (w_winner),
        .o_any    (w_any)
    );

    // Every issued op occupies a slot until popped, whether still in the gadget or in the FIFO.
    assign w_pop     = out_valid & out_ready;
    assign w_push    = r_inflight;
    assign w_credits = 2'd2 - r_occ - {1'b0, r_inflight};
    assign w_issue   = r_en & w_any & rnd_valid & ((w_credits != 2'd0) | w_pop);
    assign req_ready = w_issue ? w_grant : '0;
    assign rnd_ready = w_issue;

    // Share-wise AND-OR select: bit s only ever meets bit s of other requesters.
    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int i = 0; i < N; i++) begin
            w_a = w_a | (req_ina[i*D +: D] & {D{w_grant[i]}});
            w_b = w_b | (req_inb[i*D +: D] & {D{w_grant[i]}});
        end
    end

    // HPC3 gadget: the registers load only on issue, so they hold still while idle.
    for (genvar i = 0; i < D; i++) begin : g_row
        for (genvar j = 0; j < D; j++) begin : g_col
            if (i == j) begin : g_same
                logic r_p;
                // NOTE: datapath flops carry no reset; r_inflight alone says when they are meaningful.
                always_ff @(posedge clk) begin
                    if (w_issue) r_p <= w_a[i] & w_b[i];
                end
                assign w_term[i][j] = r_p;
            end else begin : g_cross
                localparam int P = (i < j) ? pair_idx(D, i, j) : pair_idx(D, j, i);
                logic r_u;
                logic r_v;
                always_ff @(posedge clk) begin
                    if (w_issue) begin
                        r_u <= (w_a[i] & (w_b[j] ^ rnd[P])) ^ rnd[NP+P];
                        r_v <= (~w_a[i] & rnd[P]) ^ rnd[NP+P];
                    end
                end
                assign w_term[i][j] = r_u ^ r_v;
            end
        end
        assign w_gad[i] = ^w_term[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en       <= 1'b0;
            r_ptr      <= '0;
            r_inflight <= 1'b0;
            r_fly_id   <= '0;
            r_wr       <= 1'b0;
            r_rd       <= 1'b0;
            r_occ      <= 2'd0;
            // NOTE: the two FIFO slots are reset so out_data/out_id read zero after reset.
            r_mem_data <= '{default: '0};
            r_mem_id   <= '{default: '0};
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            r_en       <= 1'b1;
            r_inflight <= w_issue;
            if (w_issue) begin
                r_fly_id <= w_winner;
                r_ptr    <= (w_winner == IW'(N - 1)) ? '0 : w_winner + 1'b1;
            end
            if (w_push) begin
                r_mem_data[r_wr] <= w_gad;
                r_mem_id[r_wr]   <= r_fly_id;
                r_wr             <= ~r_wr;
            end
            if (w_pop) r_rd <= ~r_rd;
            r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign out_valid = (r_occ != 2'd0);
    assign out_data  = r_mem_data[r_rd];
    assign out_id    = r_mem_id[r_rd];
    assign busy      = r_inflight | out_valid;

endmodule

// File: tb/tb_mskand_hpc3_sched.sv
// Bench: directed table on a d=2/N=4 instance, then a randomized run on a d=3/N=3
// instance checked against a queue-based reference model.
module tb_mskand_hpc3_sched;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance A: d=2, N=4
    logic [3:0] rv_a, rr_a;
    logic [7:0] ina_a, inb_a;
    logic       rndv_a, rndr_a, ov_a, ordy_a, busy_a;
    logic [1:0] rnd_a, od_a, oid_a;

    // Instance B: d=3, N=3
    logic [2:0] rv_b, rr_b, od_b;
    logic [8:0] ina_b, inb_b;
    logic       rndv_b, rndr_b, ov_b, ordy_b, busy_b;
    logic [5:0] rnd_b;
    logic [1:0] oid_b;

    mskand_hpc3_sched #(.D(2), .N(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(rv_a), .req_ready(rr_a),
        .req_ina(ina_a), .req_inb(inb_a), .rnd_valid(rndv_a), .rnd_ready(rndr_a),
        .rnd(rnd_a), .out_valid(ov_a), .out_ready(ordy_a), .out_data(od_a),
        .out_id(oid_a), .busy(busy_a)
    );

    mskand_hpc3_sched #(.D(3), .N(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(rv_b), .req_ready(rr_b),
        .req_ina(ina_b), .req_inb(inb_b), .rnd_valid(rndv_b), .rnd_ready(rndr_b),
        .rnd(rnd_b), .out_valid(ov_b), .out_ready(ordy_b), .out_data(od_b),
        .out_id(oid_b), .busy(busy_b)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] rv;
        logic       ordy;
        logic [3:0] e_rdy;
        logic       e_ov;
        logic [1:0] e_id;
        logic       e_x;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic [3:0] rv, input logic ordy,
                                input logic [3:0] e_rdy, input logic e_ov,
                                input logic [1:0] e_id, input logic e_x);
        vec_t v;
        v.rst = rst; v.rv = rv; v.ordy = ordy; v.e_rdy = e_rdy;
        v.e_ov = e_ov; v.e_id = e_id; v.e_x = e_x;
        return v;
    endfunction

    typedef struct {
        int   id;
        logic val;
        int   cyc;
    } ent_t;

    task automatic step_a(input logic [3:0] rv, input logic rndv, input logic ordy);
        @(negedge clk);
        rv_a = rv; rndv_a = rndv; ordy_a = ordy; rnd_a = 2'($urandom);
        #1;
    endtask

    initial begin
        ent_t q[$];
        int   mptr, win, max_occ;
        logic exp_ov, can;
        logic [2:0] exp_rdy;

        rst_n = 1'b0;
        rv_a = '0; rndv_a = 1'b0; ordy_a = 1'b0; rnd_a = '0;
        // Requester results a&b: id0=1, id1=0, id2=1, id3=1
        ina_a = 8'b01_10_11_01;
        inb_a = 8'b01_10_01_10;
        rv_b = '0; rndv_b = 1'b0; ordy_b = 1'b0; rnd_b = '0; ina_b = '0; inb_b = '0;

        // rst, req_valid, out_ready | req_ready, out_valid, out_id, xor(out_data)
        tbl.push_back(mk(0, 4'b0001, 1, 4'b0001, 0, 0, 0));
        tbl.push_back(mk(0, 4'b0000, 1, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 4'b0000, 1, 4'b0000, 1, 0, 1));
        tbl.push_back(mk(1, 4'b1111, 1, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 4'b0000, 1, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 1, 4'b0001, 0, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 1, 4'b0010, 0, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 1, 4'b0100, 1, 0, 1));
        tbl.push_back(mk(0, 4'b1111, 1, 4'b1000, 1, 1, 0));
        tbl.push_back(mk(0, 4'b1111, 1, 4'b0001, 1, 2, 1));
        tbl.push_back(mk(0, 4'b0000, 1, 4'b0000, 1, 3, 1));
        tbl.push_back(mk(0, 4'b0000, 1, 4'b0000, 1, 0, 1));
        tbl.push_back(mk(0, 4'b0000, 1, 4'b0000, 0, 0, 0));
        // Backpressure: two issues, then one more per single-cycle pop
        tbl.push_back(mk(0, 4'b1111, 0, 4'b0010, 0, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 0, 4'b0100, 0, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 0, 4'b0000, 1, 1, 0));
        tbl.push_back(mk(0, 4'b1111, 0, 4'b0000, 1, 1, 0));
        tbl.push_back(mk(0, 4'b1111, 1, 4'b1000, 1, 1, 0));
        tbl.push_back(mk(0, 4'b1111, 0, 4'b0000, 1, 2, 1));
        tbl.push_back(mk(0, 4'b1111, 0, 4'b0000, 1, 2, 1));
        tbl.push_back(mk(0, 4'b0000, 1, 4'b0000, 1, 2, 1));
        tbl.push_back(mk(0, 4'b0000, 1, 4'b0000, 1, 3, 1));
        tbl.push_back(mk(0, 4'b0000, 1, 4'b0000, 0, 0, 0));

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_req_ready", 32'(rr_a), 32'd0);
        check("rst_rnd_ready", 32'(rndr_a), 32'd0);
        check("rst_out_valid", 32'(ov_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_out_id", 32'(oid_a), 32'd0);
        check("rst_out_data", 32'(od_a), 32'd0);
        check("rst_out_valid_b", 32'(ov_b), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (tbl[k]) begin
            @(negedge clk);
            rst_n = ~tbl[k].rst;
            rv_a = tbl[k].rv; rndv_a = 1'b1; ordy_a = tbl[k].ordy; rnd_a = 2'($urandom);
            #1;
            check($sformatf("tbl%0d_req_ready", k), 32'(rr_a), 32'(tbl[k].e_rdy));
            check($sformatf("tbl%0d_rnd_ready", k), 32'(rndr_a), 32'(tbl[k].e_rdy != 4'b0000));
            check($sformatf("tbl%0d_out_valid", k), 32'(ov_a), 32'(tbl[k].e_ov));
            if (tbl[k].e_ov) begin
                check($sformatf("tbl%0d_out_id", k), 32'(oid_a), 32'(tbl[k].e_id));
                check($sformatf("tbl%0d_out_xor", k), 32'(^od_a), 32'(tbl[k].e_x));
            end
        end

        // Randomness starvation, then resume on requester 0
        for (int c = 0; c < 20; c++) begin
            step_a(4'b1111, 1'b0, 1'b1);
            check("starve_grant", 32'({rr_a, rndr_a}), 32'd0);
        end
        step_a(4'b1111, 1'b1, 1'b1);
        check("resume_req_ready", 32'(rr_a), 32'b0001);
        check("resume_rnd_ready", 32'(rndr_a), 32'd1);
        step_a(4'b0000, 1'b1, 1'b1);
        step_a(4'b0000, 1'b1, 1'b1);
        check("resume_out_valid", 32'(ov_a), 32'd1);
        check("resume_out_xor", 32'(^od_a), 32'd1);
        step_a(4'b0000, 1'b1, 1'b1);

        // Reset the cycle after an issue: nothing may emerge, pointer returns to 0
        step_a(4'b0100, 1'b1, 1'b1);
        check("midop_grant", 32'(rr_a), 32'b0100);
        @(negedge clk);
        rv_a = '0; rst_n = 1'b0;
        #1;
        check("midop_rst_out_valid", 32'(ov_a), 32'd0);
        check("midop_rst_busy", 32'(busy_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midop_rel_out_valid", 32'(ov_a), 32'd0);
        for (int c = 0; c < 3; c++) begin
            step_a(4'b0000, 1'b1, 1'b1);
            check("midop_after_out_valid", 32'(ov_a), 32'd0);
            check("midop_after_busy", 32'(busy_a), 32'd0);
        end
        step_a(4'b1111, 1'b1, 1'b1);
        check("midop_ptr_zero", 32'(rr_a), 32'b0001);
        step_a(4'b0000, 1'b0, 1'b1);
        step_a(4'b0000, 1'b0, 1'b1);
        step_a(4'b0000, 1'b0, 1'b1);

        // Randomized regression on instance B against a queue model
        mptr = 0;
        max_occ = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            rv_b   = 3'($urandom_range(0, 7));
            rndv_b = ($urandom_range(0, 4) != 0);
            ordy_b = ($urandom_range(0, 3) != 0);
            ina_b  = 9'($urandom);
            inb_b  = 9'($urandom);
            rnd_b  = 6'($urandom);
            #1;
            exp_ov = (q.size() > 0) && (q[0].cyc <= cyc - 2);
            can    = (rv_b != 3'b000) && rndv_b && ((q.size() < 2) || (exp_ov && ordy_b));
            win = -1;
            if (can) begin
                for (int k = 0; k < 3; k++) begin
                    if (win < 0 && rv_b[(mptr + k) % 3]) win = (mptr + k) % 3;
                end
            end
            exp_rdy = can ? 3'(1 << win) : 3'b000;
            check("rand_req_ready", 32'(rr_b), 32'(exp_rdy));
            check("rand_rnd_ready", 32'(rndr_b), 32'(can));
            check("rand_out_valid", 32'(ov_b), 32'(exp_ov));
            check("rand_busy", 32'(busy_b), 32'(q.size() > 0));
            if (exp_ov) begin
                check("rand_out_id", 32'(oid_b), 32'(q[0].id));
                check("rand_out_xor", 32'(^od_b), 32'(q[0].val));
            end
            if (exp_ov && ordy_b) void'(q.pop_front());
            if (can) begin
                q.push_back('{id: win, val: (^ina_b[win*3 +: 3]) & (^inb_b[win*3 +: 3]), cyc: cyc});
                mptr = (win + 1) % 3;
            end
            if (q.size() > max_occ) max_occ = q.size();
        end
        check("rand_no_overflow", 32'(max_occ <= 2), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
